// File: rtl/logic_gate_checker.sv
// Sequences the four {A,B} vectors through an external gate unit and checks its seven results.
// Optional build macro GATE_CHECK_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module logic_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       drive_a,
    output logic       drive_b,
    input  logic       not_in,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] first_fail_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state, state_nx;
    logic [1:0] vec, vec_nx;
    logic [3:0] cnt, cnt_nx;
    logic       drive_a_nx, drive_b_nx;
    logic       pass_nx;
    logic [6:0] mask_nx;
    logic [1:0] ffv_nx;
    logic [6:0] exp_out, act_out, mism;
    logic       va, vb, stop;

    assign va = vec[1];
    assign vb = vec[0];

    // Bit order matches fail_mask: not, and, or, nand, nor, xor, xnor
    assign exp_out = {~(va ^ vb), va ^ vb, ~(va | vb), ~(va & vb),
                      va | vb, va & vb, ~va};
    assign act_out = {xnor_in, xor_in, nor_in, nand_in,
                      or_in, and_in, not_in};
    assign mism    = exp_out ^ act_out;

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    assign stop = (vec == 2'd3) || (mism != 7'd0);
`else
    assign stop = (vec == 2'd3);
`endif

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    always_comb begin
        state_nx   = state;
        vec_nx     = vec;
        cnt_nx     = cnt;
        drive_a_nx = drive_a;
        drive_b_nx = drive_b;
        pass_nx    = pass;
        mask_nx    = fail_mask;
        ffv_nx     = first_fail_vec;
        unique case (state)
            IDLE: begin
                if (start) begin
                    vec_nx   = 2'd0;
                    mask_nx  = 7'd0;
                    pass_nx  = 1'b0;
                    ffv_nx   = 2'd0;
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                drive_a_nx = vec[1];
                drive_b_nx = vec[0];
                cnt_nx     = SETTLE_LD;
                state_nx   = SETTLE;
            end
            SETTLE: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                mask_nx = fail_mask | mism;
                // Only the first failing vector of a run is recorded
                if ((mism != 7'd0) && (fail_mask == 7'd0)) begin
                    ffv_nx = vec;
                end
                if (stop) begin
                    pass_nx  = (mask_nx == 7'd0);
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec + 2'd1;
                    state_nx = DRIVE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 2'd0;
            cnt            <= 4'd0;
            drive_a        <= 1'b0;
            drive_b        <= 1'b0;
            pass           <= 1'b0;
            fail_mask      <= 7'd0;
            first_fail_vec <= 2'd0;
        end else begin
            state          <= state_nx;
            vec            <= vec_nx;
            cnt            <= cnt_nx;
            drive_a        <= drive_a_nx;
            drive_b        <= drive_b_nx;
            pass           <= pass_nx;
            fail_mask      <= mask_nx;
            first_fail_vec <= ffv_nx;
        end
    end

endmodule

// File: tb/tb_logic_gate_checker.sv
// Scoreboard bench for logic_gate_checker: directed runs against a behavioural gate unit
// with selectable faults; a monitor pops expected results when done or drive checkpoints occur.
module tb_logic_gate_checker;

    localparam int S   = 2;
    localparam int PER = S + 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       drive_a, drive_b;
    logic       not_in, and_in, or_in, nand_in, nor_in, xor_in, xnor_in;
    logic       busy, done, pass;
    logic [6:0] fail_mask;
    logic [1:0] first_fail_vec;
    logic [1:0] fault;

    typedef struct {
        int unsigned at_edge;
        logic        pass;
        logic [6:0]  mask;
        logic [1:0]  ffv;
    } exp_t;

    typedef struct {
        int unsigned at_edge;
        logic [1:0]  v;
    } drv_t;

    exp_t sb_q[$];
    drv_t drv_q[$];

    int unsigned cyc = 0;
    int n_chk  = 0;
    int n_pass = 0;

    logic_gate_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .drive_a(drive_a), .drive_b(drive_b),
        .not_in(not_in), .and_in(and_in), .or_in(or_in),
        .nand_in(nand_in), .nor_in(nor_in),
        .xor_in(xor_in), .xnor_in(xnor_in),
        .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .first_fail_vec(first_fail_vec)
    );

    // fault 1: xor stuck at 0, fault 2: and computes nand
    assign not_in  = ~drive_a;
    assign and_in  = (fault == 2'd2) ? ~(drive_a & drive_b) : (drive_a & drive_b);
    assign or_in   = drive_a | drive_b;
    assign nand_in = ~(drive_a & drive_b);
    assign nor_in  = ~(drive_a | drive_b);
    assign xor_in  = (fault == 2'd1) ? 1'b0 : (drive_a ^ drive_b);
    assign xnor_in = ~(drive_a ^ drive_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (drv_q.size() > 0 && drv_q[0].at_edge == cyc) begin
                drv_t d;
                d = drv_q.pop_front();
                chk("drive_vec", int'({drive_a, drive_b}), int'(d.v));
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_edge", int'(cyc), int'(e.at_edge));
                    chk("pass", int'(pass), int'(e.pass));
                    chk("fail_mask", int'(fail_mask), int'(e.mask));
                    chk("first_fail_vec", int'(first_fail_vec), int'(e.ffv));
                    chk("busy_in_done", int'(busy), 0);
                end
            end
        end
    end

    task automatic run(input logic [1:0] f, input logic p, input logic [6:0] m,
                       input logic [1:0] ffv, input int ndrv, input int done_off,
                       input bit rel);
        int unsigned k;
        exp_t e;
        drv_t d;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        fault = f;
        start = 1'b1;
        k = cyc + 1;
        e.at_edge = k + done_off;
        e.pass = p;
        e.mask = m;
        e.ffv  = ffv;
        sb_q.push_back(e);
        for (int j = 0; j < ndrv; j++) begin
            d.at_edge = k + 1 + PER * j;
            d.v = 2'(j);
            drv_q.push_back(d);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && drv_q.size() == 0) return;
        end
        chk("timeout", 0, 1);
        sb_q.delete();
        drv_q.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_drive"}, int'({drive_a, drive_b}), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_mask"}, int'(fail_mask), 0);
        chk({nm, "_ffv"}, int'(first_fail_vec), 0);
    endtask

    initial begin
        int unsigned k;
        drv_t d;
        rst_n = 1'b1;
        start = 1'b0;
        fault = 2'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");

        // correct gates; start accepted on the edge that releases reset
        run(2'd0, 1'b1, 7'b0000000, 2'b00, 4, 4 * PER, 1'b1);
        wait_done();

        // xor stuck at 0, started in the IDLE cycle right after DONE
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        run(2'd1, 1'b0, 7'b0100000, 2'b01, 2, 2 * PER, 1'b0);
`else
        run(2'd1, 1'b0, 7'b0100000, 2'b01, 4, 4 * PER, 1'b0);
`endif
        wait_done();

        // and computes nand: fails on every vector
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        run(2'd2, 1'b0, 7'b0000010, 2'b00, 1, PER, 1'b0);
`else
        run(2'd2, 1'b0, 7'b0000010, 2'b00, 4, 4 * PER, 1'b0);
`endif
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_pass", int'(pass), 0);
        chk("hold_mask", int'(fail_mask), 7'b0000010);
        chk("hold_ffv", int'(first_fail_vec), 0);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        chk("hold_drive", int'({drive_a, drive_b}), 0);
`else
        chk("hold_drive", int'({drive_a, drive_b}), 3);
`endif

        // start pulsed while busy must not restart the run
        run(2'd0, 1'b1, 7'b0000000, 2'b00, 4, 4 * PER, 1'b0);
        repeat (5) @(negedge clk);
        chk("busy_mid_run", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset during SETTLE of vector 2 aborts with no done
        @(negedge clk);
        fault = 2'd1;
        start = 1'b1;
        k = cyc + 1;
        for (int j = 0; j < 3; j++) begin
            d.at_edge = k + 1 + PER * j;
            d.v = 2'(j);
            drv_q.push_back(d);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2 * PER + 1) @(negedge clk);
        #2;
        chk("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        chk("abort_drv_pending", drv_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("abort_still_done", int'(done), 0);

        // full run after the abort
        run(2'd0, 1'b1, 7'b0000000, 2'b00, 4, 4 * PER, 1'b1);
        wait_done();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
